pipe_stage_buf: RTL and testbench



---
 rtl/pipe_stage_buf.sv | 94 +++++++++
 tb/tb_pipe_stage_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage buffer: valid/ready on both sides, optional skid slot,
// hazard bubbles, flush, debug step-freeze and occupancy reporting.
module pipe_stage_buf #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_step,
   input  logic              i_flush,
   input  logic              i_stall,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_count
);

   localparam bit LP_SKID = (SKID != 0);

   logic              r_m_valid;
   logic [DATA_W-1:0] r_m_data;
   logic [CTRL_W-1:0] r_m_ctrl;
   logic              r_s_valid;
   logic [DATA_W-1:0] r_s_data;
   logic [CTRL_W-1:0] r_s_ctrl;

   logic w_accept;
   logic w_drain;
   logic w_m_free;

   // With a skid slot, ready depends only on state so no combinational path from i_ready.
   assign o_ready  = (LP_SKID ? ~r_s_valid : (~r_m_valid | i_ready)) & ~i_step & ~i_stall;
   assign o_valid  = r_m_valid & ~i_step;
   assign o_data   = r_m_data;
   assign o_ctrl   = r_m_ctrl;
   assign o_count  = {1'b0, r_m_valid} + {1'b0, r_s_valid};

   assign w_accept = i_valid & o_ready;
   assign w_drain  = o_valid & i_ready;
   assign w_m_free = ~r_m_valid | w_drain;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         // NOTE: payload registers are reset as well, so o_data reads 0 and S holds no stale data.
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_ctrl  <= '0;
         r_s_valid <= 1'b0;
         r_s_data  <= '0;
         r_s_ctrl  <= '0;
      end else if (i_flush) begin
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
         r_m_ctrl  <= '0;
         r_s_ctrl  <= '0;
      end else if (i_step) begin
         // Frozen for debug: every register holds.
      end else if (r_s_valid && w_drain) begin
         // Older skid entry advances into M; M stays valid.
         r_m_data <= r_s_data;
         r_m_ctrl <= r_s_ctrl;
         if (w_accept) begin
            r_s_data <= i_data;
            r_s_ctrl <= i_ctrl;
         end else begin
            r_s_valid <= 1'b0;
         end
      end else if (i_stall) begin
         if (w_m_free) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
         end
      end else if (w_m_free) begin
         if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_data;
            r_m_ctrl  <= i_ctrl;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (LP_SKID && w_accept) begin
         r_s_valid <= 1'b1;
         r_s_data  <= i_data;
         r_s_ctrl  <= i_ctrl;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: cycle-vector table on a SKID=1 instance, scoreboards on
// both a SKID=1 and a SKID=0 instance, plus hand sequences for reset and SKID=0 ready.
module tb_pipe_stage_buf;

   typedef struct {
      logic        step, flush, stall, valid, rdy;
      logic [15:0] data, ctrl;
      logic        ev, er;
      logic [1:0]  ec;
      logic [15:0] ed, ectrl;
   } vec_t;

   typedef struct {
      logic [127:0] d;
      logic [15:0]  c;
   } sb_t;

   int n_vec  = 0;
   int n_miss = 0;

   logic         clk, rst;
   logic         step, flush, stall, valid, rdy;
   logic [127:0] data;
   logic [15:0]  ctrl;
   logic         o_ready, o_valid;
   logic [127:0] o_data;
   logic [15:0]  o_ctrl;
   logic [1:0]   o_count;

   logic         s0_step, s0_flush, s0_stall, s0_valid, s0_rdy;
   logic [31:0]  s0_data;
   logic [7:0]   s0_ctrl;
   logic         s0_o_ready, s0_o_valid;
   logic [31:0]  s0_o_data;
   logic [7:0]   s0_o_ctrl;
   logic [1:0]   s0_o_count;

   sb_t sb1[$];
   sb_t sb0[$];
   sb_t e1, e0;
   vec_t vq[$];

   pipe_stage_buf #(.DATA_W(128), .CTRL_W(16), .SKID(1)) u_dut (
      .clk(clk), .i_reset(rst), .i_step(step), .i_flush(flush), .i_stall(stall),
      .i_valid(valid), .o_ready(o_ready), .i_data(data), .i_ctrl(ctrl),
      .o_valid(o_valid), .i_ready(rdy), .o_data(o_data), .o_ctrl(o_ctrl), .o_count(o_count)
   );

   pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut0 (
      .clk(clk), .i_reset(rst), .i_step(s0_step), .i_flush(s0_flush), .i_stall(s0_stall),
      .i_valid(s0_valid), .o_ready(s0_o_ready), .i_data(s0_data), .i_ctrl(s0_ctrl),
      .o_valid(s0_o_valid), .i_ready(s0_rdy), .o_data(s0_o_data), .o_ctrl(s0_o_ctrl),
      .o_count(s0_o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, f, st, v, r, input logic [15:0] d, c,
                               input logic ev, er, input logic [1:0] ec,
                               input logic [15:0] ed, ectrl);
      vec_t t;
      t.step = s;  t.flush = f; t.stall = st; t.valid = v; t.rdy = r;
      t.data = d;  t.ctrl = c;  t.ev = ev;    t.er = er;    t.ec = ec;
      t.ed = ed;   t.ectrl = ectrl;
      return t;
   endfunction

   // Scoreboards: push on accept, pop and compare on drain; reset and flush discard.
   always @(posedge rst) begin
      sb1.delete();
      sb0.delete();
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (flush) begin
            sb1.delete();
         end else begin
            if (o_valid && rdy) begin
               if (sb1.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL sb1 drain: got %0h, expected no entry", o_data);
               end else begin
                  e1 = sb1.pop_front();
                  check("sb1 data", o_data, e1.d);
                  check("sb1 ctrl", 128'(o_ctrl), 128'(e1.c));
               end
            end
            if (valid && o_ready) sb1.push_back('{data, ctrl});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (s0_o_valid && s0_rdy) begin
            if (sb0.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL sb0 drain: got %0h, expected no entry", s0_o_data);
            end else begin
               e0 = sb0.pop_front();
               check("sb0 data", 128'(s0_o_data), e0.d);
               check("sb0 ctrl", 128'(s0_o_ctrl), 128'(e0.c));
            end
         end
         if (s0_valid && s0_o_ready) sb0.push_back('{128'(s0_data), 16'(s0_ctrl)});
      end
   end

   initial begin
      logic [31:0] d0;
      logic        exp_r;
      vec_t        v;

      rst = 1'b1;
      step = 0; flush = 0; stall = 0; valid = 0; rdy = 0; data = '0; ctrl = '0;
      s0_step = 0; s0_flush = 0; s0_stall = 0; s0_valid = 0; s0_rdy = 0;
      s0_data = '0; s0_ctrl = '0;

      //              step fl st v r  data     ctrl      ev er ec ed       ectrl
      // streaming + step freeze
      vq.push_back(mk(0, 0, 0, 1, 1, 16'h1,  16'hFFFF, 0, 1, 0, 16'h0,  16'h0));
      vq.push_back(mk(0, 0, 0, 1, 1, 16'h2,  16'hFFFF, 1, 1, 1, 16'h1,  16'hFFFF));
      vq.push_back(mk(0, 0, 0, 1, 1, 16'h3,  16'hFFFF, 1, 1, 1, 16'h2,  16'hFFFF));
      vq.push_back(mk(1, 0, 0, 1, 1, 16'h4,  16'hFFFF, 0, 0, 1, 16'h3,  16'hFFFF));
      vq.push_back(mk(1, 0, 0, 1, 1, 16'h4,  16'hFFFF, 0, 0, 1, 16'h3,  16'hFFFF));
      vq.push_back(mk(1, 0, 0, 1, 1, 16'h4,  16'hFFFF, 0, 0, 1, 16'h3,  16'hFFFF));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    1, 1, 1, 16'h3,  16'hFFFF));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    0, 1, 0, 16'h3,  16'hFFFF));
      // backpressure into the skid slot, then release
      vq.push_back(mk(0, 0, 0, 1, 0, 16'hA,  16'h0A0A, 0, 1, 0, 16'h3,  16'hFFFF));
      vq.push_back(mk(0, 0, 0, 1, 0, 16'hB,  16'h0B0B, 1, 1, 1, 16'hA,  16'h0A0A));
      vq.push_back(mk(0, 0, 0, 1, 0, 16'hC,  16'h0C0C, 1, 0, 2, 16'hA,  16'h0A0A));
      vq.push_back(mk(0, 0, 0, 1, 1, 16'hC,  16'h0C0C, 1, 0, 2, 16'hA,  16'h0A0A));
      vq.push_back(mk(0, 0, 0, 1, 1, 16'hC,  16'h0C0C, 1, 1, 1, 16'hB,  16'h0B0B));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    1, 1, 1, 16'hC,  16'h0C0C));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    0, 1, 0, 16'hC,  16'h0C0C));
      // hazard bubble on an empty M
      vq.push_back(mk(0, 0, 1, 1, 1, 16'h5,  16'h00FF, 0, 0, 0, 16'hC,  16'h0C0C));
      vq.push_back(mk(0, 0, 0, 1, 1, 16'h5,  16'h00FF, 0, 1, 0, 16'hC,  16'h0000));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    1, 1, 1, 16'h5,  16'h00FF));
      // stall with S draining into M, stall holding M, then flush beats step and stall
      vq.push_back(mk(0, 0, 0, 1, 0, 16'h11, 16'h0101, 0, 1, 0, 16'h5,  16'h00FF));
      vq.push_back(mk(0, 0, 0, 1, 0, 16'h12, 16'h0202, 1, 1, 1, 16'h11, 16'h0101));
      vq.push_back(mk(0, 0, 1, 1, 1, 16'h13, 16'h0303, 1, 0, 2, 16'h11, 16'h0101));
      vq.push_back(mk(0, 0, 1, 1, 0, 16'h13, 16'h0303, 1, 0, 1, 16'h12, 16'h0202));
      vq.push_back(mk(0, 0, 0, 1, 0, 16'h13, 16'h0303, 1, 1, 1, 16'h12, 16'h0202));
      vq.push_back(mk(1, 1, 1, 1, 1, 16'h14, 16'h0404, 0, 0, 2, 16'h12, 16'h0202));
      vq.push_back(mk(0, 0, 0, 0, 1, 16'h0,  16'h0,    0, 1, 0, 16'h12, 16'h0000));

      @(negedge clk);
      check("reset o_valid", 128'(o_valid), 128'(0));
      check("reset o_count", 128'(o_count), 128'(0));
      check("reset o_data",  o_data,        128'(0));
      check("reset o_ctrl",  128'(o_ctrl),  128'(0));
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         @(posedge clk); #1;
         step = v.step; flush = v.flush; stall = v.stall; valid = v.valid; rdy = v.rdy;
         data = 128'(v.data); ctrl = v.ctrl;
         @(negedge clk);
         check($sformatf("vec%0d o_valid", i), 128'(o_valid), 128'(v.ev));
         check($sformatf("vec%0d o_ready", i), 128'(o_ready), 128'(v.er));
         check($sformatf("vec%0d o_count", i), 128'(o_count), 128'(v.ec));
         check($sformatf("vec%0d o_data",  i), o_data,        128'(v.ed));
         check($sformatf("vec%0d o_ctrl",  i), 128'(o_ctrl),  128'(v.ectrl));
      end

      // Asynchronous reset with both slots occupied.
      @(posedge clk); #1 valid = 1; rdy = 0; data = 128'h21; ctrl = 16'h2121;
      @(posedge clk); #1 data = 128'h22; ctrl = 16'h2222;
      @(posedge clk); #1 valid = 0;
      @(negedge clk);
      check("pre-reset o_count", 128'(o_count), 128'(2));
      #2 rst = 1'b1;
      #1;
      check("async reset o_valid", 128'(o_valid), 128'(0));
      check("async reset o_count", 128'(o_count), 128'(0));
      check("async reset o_ctrl",  128'(o_ctrl),  128'(0));
      check("async reset o_data",  o_data,        128'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post-reset o_ready", 128'(o_ready), 128'(1));
      check("post-reset o_count", 128'(o_count), 128'(0));

      @(posedge clk); #1 valid = 1; rdy = 1; data = 128'h31; ctrl = 16'h3131;
      @(posedge clk); #1 data = 128'h32; ctrl = 16'h3232;
      @(posedge clk); #1 valid = 0;
      @(negedge clk);
      check("post-reset stream o_data",  o_data,         128'h32);
      check("post-reset stream o_valid", 128'(o_valid),  128'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("post-reset idle o_count", 128'(o_count), 128'(0));

      // SKID=0: ready follows i_ready combinationally once M is occupied.
      d0 = 32'h40;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         s0_valid = 1'b1;
         s0_data  = d0;
         s0_ctrl  = d0[7:0];
         s0_rdy   = (k % 2 == 0);
         exp_r    = (k == 0) ? 1'b1 : s0_rdy;
         @(negedge clk);
         check($sformatf("skid0 k%0d o_ready", k), 128'(s0_o_ready), 128'(exp_r));
         check($sformatf("skid0 k%0d o_count", k), 128'(s0_o_count), (k == 0) ? 128'(0) : 128'(1));
         if (exp_r) d0 = d0 + 32'd1;
      end
      @(posedge clk); #1 s0_valid = 1'b0; s0_rdy = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("skid0 final o_count", 128'(s0_o_count), 128'(0));

      repeat (2) @(negedge clk);
      check("sb1 leftover entries", 128'(sb1.size()), 128'(0));
      check("sb0 leftover entries", 128'(sb0.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
